// File: rtl/fft_serial_sched.sv
// Ping-pong write/read scheduler for the 4-lane FFT output buffer.
// The write side steers each 8-beat FFT frame into one of two banks. The read
// side drains a full bank one lane per accepted beat. Only addresses and
// control are produced here; no data passes through this block.
module fft_serial_sched #(
  parameter int NB_ROW  = 3,
  parameter int NB_LANE = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               i_fft_valid,
  input  logic               i_ready,
  output logic               o_wr_en,
  output logic               o_wr_bank,
  output logic [NB_ROW-1:0]  o_wr_row,
  output logic               o_rd_bank,
  output logic [NB_ROW-1:0]  o_rd_row,
  output logic [NB_LANE-1:0] o_rd_lane,
  output logic               o_valid,
  output logic               o_frame_done,
  output logic               o_overflow,
  output logic               o_short_frame
);

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_ACTIVE = 2'd1;
  localparam logic [1:0] W_DROP   = 2'd2;
  localparam logic [0:0] R_IDLE   = 1'b0;
  localparam logic [0:0] R_DRAIN  = 1'b1;

  localparam logic [NB_ROW-1:0]  ROW_ONE  = NB_ROW'(1);
  localparam logic [NB_LANE-1:0] LANE_ONE = NB_LANE'(1);

  logic [1:0]         w_state_reg, w_state_next;
  logic               wr_bank_reg, wr_bank_next;
  logic [NB_ROW-1:0]  wr_row_reg, wr_row_next;
  logic [0:0]         r_state_reg, r_state_next;
  logic               rd_bank_reg, rd_bank_next;
  logic [NB_ROW-1:0]  rd_row_reg, rd_row_next;
  logic [NB_LANE-1:0] rd_lane_reg, rd_lane_next;
  logic [1:0]         full_reg;
  logic               acc;
  logic               set_full;
  logic               clr_full;

  assign acc = i_fft_valid & i_enable;

  // Write side: start a frame at row 0, step through rows, mark the bank full
  // on the last row, or drop/abort the frame.
  always_comb begin
    w_state_next  = w_state_reg;
    wr_bank_next  = wr_bank_reg;
    wr_row_next   = wr_row_reg;
    set_full      = 1'b0;
    o_wr_en       = 1'b0;
    o_overflow    = 1'b0;
    o_short_frame = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        if (acc) begin
          if (!full_reg[wr_bank_reg]) begin
            o_wr_en      = 1'b1;
            wr_row_next  = wr_row_reg + ROW_ONE;
            w_state_next = W_ACTIVE;
          end else begin
            o_overflow   = 1'b1;
            w_state_next = W_DROP;
          end
        end
      end
      W_ACTIVE: begin
        if (acc) begin
          o_wr_en = 1'b1;
          if (&wr_row_reg) begin
            set_full     = 1'b1;
            wr_bank_next = ~wr_bank_reg;
            wr_row_next  = '0;
            w_state_next = W_IDLE;
          end else begin
            wr_row_next  = wr_row_reg + ROW_ONE;
          end
        end else begin
          // Frame ended early: the bank stays empty and is reused from row 0.
          o_short_frame = 1'b1;
          wr_row_next   = '0;
          w_state_next  = W_IDLE;
        end
      end
      W_DROP: begin
        if (!i_fft_valid) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // Read side: drain a full bank lane by lane, chaining into the other bank
  // without a bubble when it is already full.
  always_comb begin
    r_state_next = r_state_reg;
    rd_bank_next = rd_bank_reg;
    rd_row_next  = rd_row_reg;
    rd_lane_next = rd_lane_reg;
    clr_full     = 1'b0;
    o_frame_done = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        if (full_reg[rd_bank_reg]) begin
          r_state_next = R_DRAIN;
          rd_row_next  = '0;
          rd_lane_next = '0;
        end
      end
      R_DRAIN: begin
        if (i_ready) begin
          if (&rd_lane_reg) begin
            rd_lane_next = '0;
            if (&rd_row_reg) begin
              o_frame_done = 1'b1;
              clr_full     = 1'b1;
              rd_bank_next = ~rd_bank_reg;
              rd_row_next  = '0;
              if (!full_reg[~rd_bank_reg]) r_state_next = R_IDLE;
            end else begin
              rd_row_next  = rd_row_reg + ROW_ONE;
            end
          end else begin
            rd_lane_next = rd_lane_reg + LANE_ONE;
          end
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // State and address registers for both sides.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_state_reg <= W_IDLE;
      wr_bank_reg <= 1'b0;
      wr_row_reg  <= '0;
      r_state_reg <= R_IDLE;
      rd_bank_reg <= 1'b0;
      rd_row_reg  <= '0;
      rd_lane_reg <= '0;
    end else begin
      w_state_reg <= w_state_next;
      wr_bank_reg <= wr_bank_next;
      wr_row_reg  <= wr_row_next;
      r_state_reg <= r_state_next;
      rd_bank_reg <= rd_bank_next;
      rd_row_reg  <= rd_row_next;
      rd_lane_reg <= rd_lane_next;
    end
  end

  // Per-bank full flags; a set and a clear in the same cycle always hit
  // different banks, so each flag sees at most one of them.
  for (genvar gi = 0; gi < 2; gi++) begin : g_full
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        full_reg[gi] <= 1'b0;
      end else if (set_full && (wr_bank_reg == gi[0])) begin
        full_reg[gi] <= 1'b1;
      end else if (clr_full && (rd_bank_reg == gi[0])) begin
        full_reg[gi] <= 1'b0;
      end
    end
  end

  assign o_wr_bank = wr_bank_reg;
  assign o_wr_row  = wr_row_reg;
  assign o_rd_bank = rd_bank_reg;
  assign o_rd_row  = rd_row_reg;
  assign o_rd_lane = rd_lane_reg;
  assign o_valid   = (r_state_reg == R_DRAIN);

endmodule

// File: tb/tb_fft_serial_sched.sv
// Bench for fft_serial_sched: directed scenarios plus a randomized phase,
// checked against a frame-level model of the expected write and read streams.
module tb_fft_serial_sched;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_enable;
  logic       i_fft_valid;
  logic       i_ready;
  logic       o_wr_en;
  logic       o_wr_bank;
  logic [2:0] o_wr_row;
  logic       o_rd_bank;
  logic [2:0] o_rd_row;
  logic [1:0] o_rd_lane;
  logic       o_valid;
  logic       o_frame_done;
  logic       o_overflow;
  logic       o_short_frame;

  fft_serial_sched #(.NB_ROW(3), .NB_LANE(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
    .i_fft_valid(i_fft_valid), .i_ready(i_ready),
    .o_wr_en(o_wr_en), .o_wr_bank(o_wr_bank), .o_wr_row(o_wr_row),
    .o_rd_bank(o_rd_bank), .o_rd_row(o_rd_row), .o_rd_lane(o_rd_lane),
    .o_valid(o_valid), .o_frame_done(o_frame_done),
    .o_overflow(o_overflow), .o_short_frame(o_short_frame)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ready_mode = 0;            // 0 hold, 1 toggle, 2 random
  int cyc = 0;
  int last_wr7_cyc = -1;
  int first_valid_cyc = -1;
  int last_acc_cyc = -1;
  int seen_ovf = 0, seen_short = 0, seen_done = 0;
  int exp_ovf = 0, exp_short = 0, exp_done = 0;
  bit mdl_bank = 1'b0;
  bit prev_stall = 1'b0, prev_valid = 1'b0;
  logic [5:0] prev_beat = '0;
  logic [5:0] mon_beat;
  logic [3:0] wr_q[$], exp_wr[$];
  logic [5:0] rd_q[$], exp_rd[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: log writes and accepted read beats, count pulses, check hold rules.
  always @(negedge i_clk) begin
    cyc++;
    if (!i_rst_n) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      mon_beat = {o_rd_bank, o_rd_row, o_rd_lane};
      if (prev_stall) begin
        check("hold_beat", 32'(mon_beat), 32'(prev_beat));
        check("hold_valid", 32'(o_valid), 32'd1);
      end
      if (o_wr_en) begin
        wr_q.push_back({o_wr_bank, o_wr_row});
        if (o_wr_row == 3'd7) last_wr7_cyc = cyc;
      end
      if (o_valid && !prev_valid) first_valid_cyc = cyc;
      check("frame_done", 32'(o_frame_done),
            32'(o_valid && i_ready && (mon_beat[4:0] == 5'b11111)));
      if (o_valid && i_ready) begin
        rd_q.push_back(mon_beat);
        last_acc_cyc = cyc;
      end
      if (o_overflow) seen_ovf++;
      if (o_short_frame) seen_short++;
      if (o_frame_done) seen_done++;
      prev_stall = o_valid && !i_ready;
      prev_beat  = mon_beat;
      prev_valid = o_valid;
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
    if (ready_mode == 1) i_ready = ~i_ready;
    else if (ready_mode == 2) i_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_logs();
    wr_q.delete(); rd_q.delete(); exp_wr.delete(); exp_rd.delete();
    seen_ovf = 0; seen_short = 0; seen_done = 0;
    exp_ovf = 0; exp_short = 0; exp_done = 0;
    first_valid_cyc = -1; last_wr7_cyc = -1; last_acc_cyc = -1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; i_fft_valid = 1'b0; i_enable = 1'b1; i_ready = 1'b1;
    ready_mode = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    mdl_bank = 1'b0;
    clear_logs();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_en"},  32'(o_wr_en), 0);
    check({tag, "_wr_bank"}, 32'(o_wr_bank), 0);
    check({tag, "_wr_row"}, 32'(o_wr_row), 0);
    check({tag, "_rd_bank"}, 32'(o_rd_bank), 0);
    check({tag, "_rd_row"}, 32'(o_rd_row), 0);
    check({tag, "_rd_lane"}, 32'(o_rd_lane), 0);
    check({tag, "_valid"},  32'(o_valid), 0);
    check({tag, "_done"},   32'(o_frame_done), 0);
    check({tag, "_ovf"},    32'(o_overflow), 0);
    check({tag, "_short"},  32'(o_short_frame), 0);
  endtask

  // Frame-level model: a complete frame lands in the current bank and is later
  // read row-major, lane-minor; a short frame writes rows but is never read.
  task automatic model_frame(input int len);
    for (int r = 0; r < len; r++) exp_wr.push_back({mdl_bank, 3'(r)});
    if (len == 8) begin
      for (int r = 0; r < 8; r++)
        for (int l = 0; l < 4; l++) exp_rd.push_back({mdl_bank, 3'(r), 2'(l)});
      exp_done++;
      mdl_bank = ~mdl_bank;
    end else begin
      exp_short++;
    end
  endtask

  // Send one frame: len accepted beats; via_enable keeps valid high for 8
  // cycles and ends the frame by dropping enable; dropped frames expect overflow.
  task automatic send_frame(input int len, input bit via_enable, input bit dropped);
    int ncyc;
    ncyc = (via_enable || dropped) ? 8 : len;
    for (int i = 0; i < ncyc; i++) begin
      i_fft_valid = 1'b1;
      i_enable    = (i < len);
      step();
    end
    i_fft_valid = 1'b0;
    i_enable    = 1'b1;
    if (dropped) exp_ovf++;
    else model_frame(len);
  endtask

  task automatic wait_reads(input string tag);
    int budget;
    budget = 800;
    while (rd_q.size() < exp_rd.size() && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check({tag, "_timeout"}, rd_q.size(), exp_rd.size());
    repeat (4) step();
  endtask

  task automatic end_segment(input string tag);
    int n;
    check({tag, "_wr_count"}, wr_q.size(), exp_wr.size());
    n = (wr_q.size() < exp_wr.size()) ? wr_q.size() : exp_wr.size();
    for (int i = 0; i < n; i++) check({tag, "_wr"}, 32'(wr_q[i]), 32'(exp_wr[i]));
    check({tag, "_rd_count"}, rd_q.size(), exp_rd.size());
    n = (rd_q.size() < exp_rd.size()) ? rd_q.size() : exp_rd.size();
    for (int i = 0; i < n; i++) check({tag, "_rd"}, 32'(rd_q[i]), 32'(exp_rd[i]));
    check({tag, "_overflow"}, seen_ovf, exp_ovf);
    check({tag, "_short"}, seen_short, exp_short);
    check({tag, "_done"}, seen_done, exp_done);
    clear_logs();
  endtask

  initial begin
    int len;
    int wait_budget;
    bit ven;
    i_rst_n = 1'b0; i_enable = 1'b0; i_fft_valid = 1'b0; i_ready = 1'b0;
    @(posedge i_clk);
    #1;
    check_outputs_zero("reset");
    do_reset();

    // 1: single frame, ready held high
    step();
    send_frame(8, 1'b0, 1'b0);
    wait_reads("t1");
    check("t1_latency", first_valid_cyc - last_wr7_cyc, 2);
    check("t1_span", last_acc_cyc - first_valid_cyc + 1, 32);
    end_segment("t1");

    // 2: two back-to-back frames, a 32-cycle gap, then a third; no bubbles
    do_reset();
    send_frame(8, 1'b0, 1'b0);
    send_frame(8, 1'b0, 1'b0);
    repeat (32) step();
    send_frame(8, 1'b0, 1'b0);
    wait_reads("t2");
    check("t2_span", last_acc_cyc - first_valid_cyc + 1, 96);
    end_segment("t2");

    // 3: ready toggling during the drain
    do_reset();
    ready_mode = 1;
    send_frame(8, 1'b0, 1'b0);
    wait_reads("t3");
    end_segment("t3");

    // 4: ready low, three frames; the third overflows
    do_reset();
    i_ready = 1'b0;
    send_frame(8, 1'b0, 1'b0);
    send_frame(8, 1'b0, 1'b0);
    send_frame(8, 1'b0, 1'b1);
    repeat (5) step();
    check("t4_no_reads", rd_q.size(), 0);
    i_ready = 1'b1;
    wait_reads("t4");
    end_segment("t4");

    // 5: short frames (valid drop, then enable drop) followed by a full frame
    do_reset();
    send_frame(5, 1'b0, 1'b0);
    repeat (40) step();
    send_frame(3, 1'b1, 1'b0);
    repeat (40) step();
    check("t5_no_reads", rd_q.size(), 0);
    send_frame(8, 1'b0, 1'b0);
    wait_reads("t5");
    end_segment("t5");

    // 6: asynchronous reset during the drain at row 3
    do_reset();
    send_frame(8, 1'b0, 1'b0);
    wait_budget = 200;
    while (rd_q.size() < 13 && wait_budget > 0) begin
      step();
      wait_budget--;
    end
    check("t6_row_before_reset", 32'(o_rd_row), 3);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_async");
    do_reset();
    send_frame(8, 1'b0, 1'b0);
    wait_reads("t6");
    end_segment("t6");

    // 7: randomized frames, lengths, enable drops and ready pattern
    do_reset();
    ready_mode = 2;
    for (int k = 0; k < 10; k++) begin
      len = $urandom_range(1, 11);
      if (len > 8) len = 8;
      ven = 1'($urandom_range(0, 1));
      send_frame(len, ven, 1'b0);
      wait_reads("rand");
      repeat ($urandom_range(1, 6)) step();
    end
    end_segment("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
